fp32_acc_unit: RTL and testbench

Streaming fp32 accumulator that sits directly downstream of the combinational fp32add stage in the tensor-core datapath. It consumes a packet of fp32 values (products from the MAC array) over a valid/ready handshake and folds them into a running sum through one internal fp32add instance (ports a, b, result). It emits one fp32 sum per packet with the element count. The sum is held until the consumer accepts it.

---
 rtl/fp32_acc_unit.sv | 212 +++++++++++++++++++++
 tb/tb_fp32_acc_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_acc_unit.sv
// Streaming fp32 packet accumulator built around one combinational fp32 adder (RNE).
// Optional sticky NaN/Inf status flags: define FP32_ACC_STATUS_EN.

module fp32add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf, swap, sub, stk, rnd_up;
  logic [31:0] big, sml;
  logic [8:0]  e_big, e_sml, d, sh, e_n, e_r;
  logic [23:0] m_big, m_sml;
  logic [26:0] m_sml_x, m_sml_sh, nrm;
  logic [27:0] m_big_x, m_sml_al, sum;
  logic [4:0]  lz;
  logic [24:0] mr;
  logic [22:0] frac;

  always_comb begin
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);

    // Order by magnitude so the alignment shift is always on the smaller operand
    swap  = b[30:0] > a[30:0];
    big   = swap ? b : a;
    sml   = swap ? a : b;
    sub   = big[31] ^ sml[31];
    e_big = (big[30:23] == 8'd0) ? 9'd1 : {1'b0, big[30:23]};
    e_sml = (sml[30:23] == 8'd0) ? 9'd1 : {1'b0, sml[30:23]};
    m_big = {|big[30:23], big[22:0]};
    m_sml = {|sml[30:23], sml[22:0]};
    d     = e_big - e_sml;

    m_sml_x = {m_sml, 3'b000};
    if (d >= 9'd27) begin
      m_sml_sh = '0;
      stk      = |m_sml;
    end else begin
      m_sml_sh = m_sml_x >> d;
      stk      = |(m_sml_x & ~({27{1'b1}} << d));
    end
    m_sml_al = {1'b0, m_sml_sh[26:1], m_sml_sh[0] | stk};
    m_big_x  = {1'b0, m_big, 3'b000};
    sum      = sub ? (m_big_x - m_sml_al) : (m_big_x + m_sml_al);

    // Normalise; the left shift is capped so small results land as subnormals
    lz  = lzc27(sum[26:0]);
    sh  = '0;
    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e_n = e_big + 9'd1;
    end else begin
      sh  = ({4'b0, lz} < e_big) ? {4'b0, lz} : (e_big - 9'd1);
      nrm = sum[26:0] << sh;
      e_n = nrm[26] ? (e_big - sh) : 9'd0;
    end

    rnd_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mr     = {1'b0, nrm[26:3]} + 25'(rnd_up);
    e_r    = e_n;
    if (mr[24])
      e_r = e_n + 9'd1;
    else if ((e_n == 9'd0) && mr[23])
      e_r = 9'd1;
    frac = mr[24] ? mr[23:1] : mr[22:0];

    if (a_nan || b_nan || (a_inf && b_inf && (a[31] ^ b[31])))
      result = 32'h7FC0_0000;
    else if (a_inf)
      result = a;
    else if (b_inf)
      result = b;
    else if (sum == 28'd0)
      result = {a[31] & b[31], 31'd0};
    else if (e_r >= 9'd255)
      result = {big[31], 8'hFF, 23'd0};
    else
      result = {big[31], e_r[7:0], frac};
  end

endmodule

module fp32_acc_unit #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc,
  output logic [1:0]       out_status
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e           state_q;
  logic [31:0]      acc_q, acc_d, sum_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q, out_trunc_q;
  logic             beat, hs, lim;

  fp32add u_add (
    .a      (acc_q),
    .b      (in_data),
    .result (sum_w)
  );

  assign beat  = in_valid & in_ready_q;
  assign hs    = out_valid_q & out_ready;
  // First beat bypasses the adder so -0 and NaN payloads are kept bit-exact
  assign acc_d = (state_q == S_IDLE) ? in_data : sum_w;
  assign cnt_d = (state_q == S_IDLE) ? CNT_W'(1) : (cnt_q + CNT_W'(1));
  assign lim   = (cnt_d == CNT_W'(MAX_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= 32'd0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (in_last || lim) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_trunc_q <= ~in_last;
            end else begin
              state_q    <= S_ACCUM;
              in_ready_q <= 1'b1;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (hs) begin
            state_q     <= S_IDLE;
            acc_q       <= 32'd0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_trunc_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_trunc = out_trunc_q;

`ifdef FP32_ACC_STATUS_EN
  logic nan_q, inf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else if (hs) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else if (beat) begin
      nan_q <= nan_q | ((&acc_d[30:23]) & (|acc_d[22:0]));
      inf_q <= inf_q | ((&acc_d[30:23]) & ~(|acc_d[22:0]));
    end
  end

  assign out_status = {nan_q, inf_q};
`else
  assign out_status = 2'b00;
`endif

endmodule

// File: tb/tb_fp32_acc_unit.sv
// Directed bench for fp32_acc_unit (MAX_LEN=4) with hand-computed fp32 sums.
module tb_fp32_acc_unit;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

`ifdef FP32_ACC_STATUS_EN
  localparam logic [1:0] ST_NAN_INF = 2'b11;
  localparam logic [1:0] ST_INF     = 2'b01;
`else
  localparam logic [1:0] ST_NAN_INF = 2'b00;
  localparam logic [1:0] ST_INF     = 2'b00;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;
  logic [1:0]       out_status;

  int n_chk = 0;
  int n_err = 0;

  fp32_acc_unit #(.MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_trunc  (out_trunc),
    .out_status (out_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [31:0] exp_d, input int exp_cnt,
                      input logic exp_tr, input logic [1:0] exp_st);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    check({tag, "_trunc"}, 32'(out_trunc), 32'(exp_tr));
    check({tag, "_status"}, 32'(out_status), 32'(exp_st));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_trunc", 32'(out_trunc), 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // 3.0 + 4.0 = 7.0
    send(32'h4040_0000, 1'b0);
    send(32'h4080_0000, 1'b1);
    recv("p34", 32'h40E0_0000, 2, 1'b0, 2'b00);

    // Single beat bypasses the adder; -0 must survive exactly
    send(32'h4040_0000, 1'b1);
    recv("single", 32'h4040_0000, 1, 1'b0, 2'b00);
    send(32'h8000_0000, 1'b1);
    recv("negzero", 32'h8000_0000, 1, 1'b0, 2'b00);

    send(32'hC040_0000, 1'b0);
    send(32'hC080_0000, 1'b1);
    recv("neg", 32'hC0E0_0000, 2, 1'b0, 2'b00);

    // x + (-x) rounds to +0
    send(32'h3F80_0000, 1'b0);
    send(32'hBF80_0000, 1'b1);
    recv("cancel", 32'h0000_0000, 2, 1'b0, 2'b00);

    // Backpressure: result held stable, no input accepted
    send(32'h4040_0000, 1'b0);
    send(32'hC000_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, 32'h3F80_0000);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    recv("stall", 32'h3F80_0000, 2, 1'b0, 2'b00);
    @(negedge clk);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);

    // Truncation at MAX_LEN, then the leftover beats form a new packet
    for (int i = 0; i < 4; i++) send(32'h3F80_0000, 1'b0);
    recv("trunc", 32'h4080_0000, 4, 1'b1, 2'b00);
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    recv("after_trunc", 32'h4000_0000, 2, 1'b0, 2'b00);

    // in_last on exactly the MAX_LEN-th beat is not a truncation
    for (int i = 0; i < 3; i++) send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    recv("full_last", 32'h40A0_0000, 4, 1'b0, 2'b00);

    // Special values
    send(32'h4040_0000, 1'b0);
    send(32'h7F80_0000, 1'b1);
    recv("inf", 32'h7F80_0000, 2, 1'b0, ST_INF);
    send(32'h4040_0000, 1'b0);
    send(32'h7F80_0000, 1'b0);
    send(32'h7FC0_0000, 1'b1);
    @(negedge clk);
    check("nan_exp", 32'(out_data[30:23]), 32'h0000_00FF);
    check("nan_man_nz", 32'(|out_data[22:0]), 32'd1);
    recv("nan", 32'h7FC0_0000, 3, 1'b0, ST_NAN_INF);

    // Reset mid-packet discards the partial sum
    send(32'h4040_0000, 1'b0);
    send(32'h4040_0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    send(32'h4040_0000, 1'b1);
    recv("post_rst", 32'h4040_0000, 1, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
